// File: rtl/zigzag_reorder_buffer.sv
// rtl/zigzag_reorder_buffer.sv - ping-pong 8x8 coefficient buffer, row-major in, zigzag out
module zigzag_reorder_buffer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_en,
  input  logic                  I_data_valid,
  input  logic [DATA_WIDTH-1:0] I_d,
  output logic [DATA_WIDTH-1:0] O_q,
  output logic                  O_data_valid,
  output logic                  O_block_start,
  output logic                  O_block_end,
  output logic                  O_overflow
);

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {S_IDLE, S_READ} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [128];
  logic [1:0]            full;
  logic [1:0]            full_set;
  logic [1:0]            full_clr;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [5:0]            wr_idx;
  logic [5:0]            rd_k;
  logic                  rd_ready;
  logic                  rd_last;
  logic                  wr_blocked;
  logic                  wr_fire;
  logic                  wr_done;

  assign rd_ready   = full[rd_bank];
  assign rd_last    = I_en && (state == S_READ) && (rd_k == 6'd63);
  // A bank finishing its drain this edge can take a new sample 0 on the same edge.
  assign wr_blocked = full[wr_bank] && !(rd_last && (rd_bank == wr_bank));
  assign wr_fire    = I_en && I_data_valid && !wr_blocked;
  assign wr_done    = wr_fire && (wr_idx == 6'd63);
  assign full_set   = wr_done ? (2'b01 << wr_bank) : 2'b00;
  assign full_clr   = rd_last ? (2'b01 << rd_bank) : 2'b00;

  always_ff @(posedge I_clk) begin
    if (wr_fire) begin
      mem[{wr_bank, wr_idx}] <= I_d;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_idx     <= 6'd0;
      wr_bank    <= 1'b0;
      full       <= 2'b00;
      O_overflow <= 1'b0;
    end else if (I_en) begin
      full <= (full & ~full_clr) | full_set;
      if (wr_fire) begin
        wr_idx <= wr_idx + 6'd1;
        if (wr_done) begin
          wr_bank <= ~wr_bank;
        end
      end
      if (I_data_valid && wr_blocked) begin
        O_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state         <= S_IDLE;
      rd_k          <= 6'd0;
      rd_bank       <= 1'b0;
      O_q           <= '0;
      O_data_valid  <= 1'b0;
      O_block_start <= 1'b0;
      O_block_end   <= 1'b0;
    end else if (I_en) begin
      O_data_valid  <= 1'b0;
      O_block_start <= 1'b0;
      O_block_end   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rd_ready) begin
            state <= S_READ;
            rd_k  <= 6'd0;
          end
        end
        S_READ: begin
          O_q           <= mem[{rd_bank, ZZ[rd_k]}];
          O_data_valid  <= 1'b1;
          O_block_start <= (rd_k == 6'd0);
          O_block_end   <= (rd_k == 6'd63);
          rd_k          <= rd_k + 6'd1;
          // rd_k wraps to 0, so staying in READ continues straight into the next block
          if (rd_k == 6'd63) begin
            rd_bank <= ~rd_bank;
            if (!full[~rd_bank]) begin
              state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zigzag_reorder_buffer.sv
// tb/tb_zigzag_reorder_buffer.sv - directed self-checking bench for zigzag_reorder_buffer
module tb_zigzag_reorder_buffer;

  logic        I_clk = 1'b0;
  logic        I_rst_n = 1'b0;
  logic        I_en = 1'b1;
  logic        I_data_valid = 1'b0;
  logic [15:0] I_d = 16'd0;
  logic [15:0] O_q;
  logic        O_data_valid;
  logic        O_block_start;
  logic        O_block_end;
  logic        O_overflow;

  zigzag_reorder_buffer #(.DATA_WIDTH(16)) dut (
    .I_clk(I_clk),
    .I_rst_n(I_rst_n),
    .I_en(I_en),
    .I_data_valid(I_data_valid),
    .I_d(I_d),
    .O_q(O_q),
    .O_data_valid(O_data_valid),
    .O_block_start(O_block_start),
    .O_block_end(O_block_end),
    .O_overflow(O_overflow)
  );

  always #5 I_clk = ~I_clk;

  int zz [64] = '{
    0,  1,  8,  16, 9,  2,  3,  10, 17, 24, 32, 25, 18, 11, 4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6,  7,  14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  int          n_assert = 0;
  int          n_fail = 0;
  logic [15:0] exp_q [$];
  int          out_k = 0;
  int          run = 0;
  int          max_run = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; scoreboards the registered outputs produced by an enabled edge.
  task automatic tick();
    logic en_s;
    logic [15:0] e;
    en_s = I_en;
    @(posedge I_clk);
    #1;
    if (en_s) begin
      if (O_data_valid) begin
        run++;
        if (run > max_run) max_run = run;
        if (exp_q.size() == 0) begin
          check("unexpected_out", {31'd0, O_data_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("q", {16'd0, O_q}, {16'd0, e});
          check("start", {31'd0, O_block_start}, (out_k == 0) ? 32'd1 : 32'd0);
          check("end", {31'd0, O_block_end}, (out_k == 63) ? 32'd1 : 32'd0);
          out_k = (out_k + 1) % 64;
        end
      end else begin
        run = 0;
        check("idle_flags", {30'd0, O_block_start, O_block_end}, 32'd0);
      end
    end
  endtask

  task automatic push_block(input int base);
    for (int k = 0; k < 64; k++) exp_q.push_back(16'(base + zz[k]));
  endtask

  task automatic feed_block(input int base, input bit burst);
    for (int i = 0; i < 64; i++) begin
      I_data_valid = 1'b1;
      I_d = 16'(base + i);
      tick();
      if (burst && (i % 8 == 7)) begin
        I_data_valid = 1'b0;
        tick();
      end
    end
    I_data_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < budget) begin
      tick();
      cnt++;
    end
    check("drain_left", exp_q.size(), 32'd0);
    tick();
    check("valid_after", {31'd0, O_data_valid}, 32'd0);
  endtask

  task automatic wait_out_k(input int k);
    int cnt;
    cnt = 0;
    while (out_k != k && cnt < 200) begin
      tick();
      cnt++;
    end
    check("wait_out_k", out_k, k);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {11'd0, O_q, O_data_valid, O_block_start, O_block_end, O_overflow}, 32'd0);
  endtask

  task automatic do_reset();
    I_rst_n = 1'b0;
    I_data_valid = 1'b0;
    exp_q.delete();
    out_k = 0;
    tick();
    tick();
    check_all_zero("reset_outputs");
    I_rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #2;
    check_all_zero("por_outputs");
    do_reset();

    // single block, index values, latency
    push_block(0);
    feed_block(0, 1'b0);
    tick();
    check("lat_e1_valid", {31'd0, O_data_valid}, 32'd0);
    tick();
    check("lat_e2_valid", {31'd0, O_data_valid}, 32'd1);
    check("lat_e2_q", {16'd0, O_q}, 32'd0);
    drain(100);

    // bursts of 8 + idle, two blocks
    push_block(100);
    push_block(200);
    feed_block(100, 1'b1);
    feed_block(200, 1'b1);
    drain(200);
    check("burst_no_ovf", {31'd0, O_overflow}, 32'd0);

    // three blocks back-to-back
    max_run = 0;
    push_block(300);
    push_block(400);
    push_block(4000);
    feed_block(300, 1'b0);
    feed_block(400, 1'b0);
    feed_block(4000, 1'b0);
    drain(200);
    check("b2b_run", max_run, 32'd192);
    check("b2b_no_ovf", {31'd0, O_overflow}, 32'd0);

    // enable gap at output index 20; garbage on I_d while disabled must not be written
    push_block(600);
    feed_block(600, 1'b0);
    wait_out_k(21);
    I_en = 1'b0;
    I_data_valid = 1'b1;
    I_d = 16'hdead;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("freeze_q", {16'd0, O_q}, 32'(600 + zz[20]));
      check("freeze_valid", {31'd0, O_data_valid}, 32'd1);
    end
    I_data_valid = 1'b0;
    I_en = 1'b1;
    drain(100);
    push_block(800);
    feed_block(800, 1'b0);
    drain(100);

    // overflow: read side stalled while a third block arrives
    do_reset();
    force dut.rd_ready = 1'b0;
    feed_block(1000, 1'b0);
    feed_block(2000, 1'b0);
    check("ovf_before", {31'd0, O_overflow}, 32'd0);
    I_data_valid = 1'b1;
    I_d = 16'd3000;
    tick();
    check("ovf_set", {31'd0, O_overflow}, 32'd1);
    feed_block(3000, 1'b0);
    check("stall_no_valid", {31'd0, O_data_valid}, 32'd0);
    release dut.rd_ready;
    push_block(1000);
    push_block(2000);
    drain(300);
    push_block(5000);
    feed_block(5000, 1'b0);
    drain(100);
    check("ovf_sticky", {31'd0, O_overflow}, 32'd1);

    // reset mid-write at index 30
    for (int i = 0; i < 30; i++) begin
      I_data_valid = 1'b1;
      I_d = 16'(64 + i);
      tick();
    end
    I_d = 16'd94;
    #2;
    I_rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid_write");
    I_data_valid = 1'b0;
    exp_q.delete();
    out_k = 0;
    tick();
    I_rst_n = 1'b1;

    // reset mid-read, then a clean block
    push_block(500);
    feed_block(500, 1'b0);
    wait_out_k(10);
    check("pre_rst_valid", {31'd0, O_data_valid}, 32'd1);
    #2;
    I_rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid_read");
    exp_q.delete();
    out_k = 0;
    tick();
    I_rst_n = 1'b1;
    push_block(700);
    feed_block(700, 1'b0);
    tick();
    tick();
    check("post_rst_first_q", {16'd0, O_q}, 32'd700);
    drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
